// File: rtl/fft_out_stream_if.sv
// fft_out_stream_if: bank read-side inputs and natural-order output stream of fft_out_stream.
// Revision 1.0
`default_nettype none

interface fft_out_stream_if #(
  parameter int DWIDTH = 32
);
  logic [10:0]       i_point;
  logic              i_valid;
  logic              i_bank_sel;
  logic [DWIDTH-1:0] i_rdata0;
  logic [DWIDTH-1:0] i_rdata1;
  logic              i_ready;
  logic [DWIDTH-1:0] o_data;
  logic              o_valid;
  logic              o_sop;
  logic              o_eop;
  logic [9:0]        o_index;
  logic              o_overflow;
  logic [6:0]        o_level;

  modport slave (
    input  i_point, i_valid, i_bank_sel, i_rdata0, i_rdata1, i_ready,
    output o_data, o_valid, o_sop, o_eop, o_index, o_overflow, o_level
  );

  modport master (
    output i_point, i_valid, i_bank_sel, i_rdata0, i_rdata1, i_ready,
    input  o_data, o_valid, o_sop, o_eop, o_index, o_overflow, o_level
  );
endinterface

`default_nettype wire

// File: rtl/fft_out_stream.sv
// fft_out_stream: tags bank read samples with frame bin index and buffers them in a FWFT FIFO.
// Revision 1.0
`default_nettype none

module fft_out_stream #(
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  fft_out_stream_if.slave  bus
);
  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         EW        = DWIDTH + 12;
  localparam logic [6:0] DEPTH_LVL = 7'(FIFO_DEPTH);
  localparam logic [10:0] MAX_PT   = 11'd1024;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [6:0]        level;
  logic              overflow;
  logic [9:0]        r_idx;
  logic [10:0]       r_npt;

  logic [DWIDTH-1:0] sample;
  logic [10:0]       pt_eff;
  logic [10:0]       npt_cur;
  logic              is_first;
  logic              is_last;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic [EW-1:0]     head;

  assign sample   = bus.i_bank_sel ? bus.i_rdata1 : bus.i_rdata0;
  assign pt_eff   = (bus.i_point < 11'd2 || bus.i_point > MAX_PT) ? MAX_PT : bus.i_point;
  assign is_first = (r_idx == 10'd0);
  // Bin 0 uses the frame size being loaded in the same cycle.
  assign npt_cur  = is_first ? pt_eff : r_npt;
  assign is_last  = ({1'b0, r_idx} == (npt_cur - 11'd1));

  assign not_empty = (level != 7'd0);
  assign pop       = not_empty && bus.i_ready;
  assign push      = bus.i_valid && ((level < DEPTH_LVL) || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
      r_npt <= MAX_PT;
    end else if (bus.i_valid) begin
      if (is_first) r_npt <= pt_eff;
      r_idx <= is_last ? 10'd0 : r_idx + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sample, is_first, is_last, r_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + 7'd1;
        2'b01:   level <= level - 7'd1;
        default: level <= level;
      endcase
      if (bus.i_valid && !push) overflow <= 1'b1;
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.o_valid    = not_empty;
  assign bus.o_data     = not_empty ? head[EW-1:12] : '0;
  assign bus.o_sop      = not_empty & head[11];
  assign bus.o_eop      = not_empty & head[10];
  assign bus.o_index    = not_empty ? head[9:0] : 10'd0;
  assign bus.o_overflow = overflow;
  assign bus.o_level    = level;
endmodule

`default_nettype wire

// File: tb/tb_fft_out_stream.sv
// tb_fft_out_stream: directed and randomized checks of fft_out_stream against a queue-based model.
// Revision 1.0
`default_nettype none

module tb_fft_out_stream;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fft_out_stream_if #(.DWIDTH(DW)) bus ();

  fft_out_stream #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            sop;
    bit            eop;
    int            idx;
  } entry_t;

  entry_t mq[$];
  int     m_idx = 0;
  int     m_npt = 1024;
  bit     m_ovf = 1'b0;
  bit     model_ok = 1'b0;
  int     n_assert = 0;
  int     n_fail = 0;

  function automatic int eff_pt(int p);
    return (p < 2 || p > 1024) ? 1024 : p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame bins counted per valid sample, FIFO as a bounded queue.
  always @(posedge clk) begin : model
    bit     pop, full;
    int     n;
    entry_t e;
    if (reset) begin
      mq.delete();
      m_idx = 0;
      m_npt = 1024;
      m_ovf = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      pop  = (mq.size() != 0) && bus.i_ready;
      full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (bus.i_valid) begin
        n = (m_idx == 0) ? eff_pt(int'(bus.i_point)) : m_npt;
        if (m_idx == 0) m_npt = n;
        e.data = bus.i_bank_sel ? bus.i_rdata1 : bus.i_rdata0;
        e.sop  = (m_idx == 0);
        e.eop  = (m_idx == n - 1);
        e.idx  = m_idx;
        if (!full || pop) mq.push_back(e);
        else m_ovf = 1'b1;
        m_idx = (m_idx == n - 1) ? 0 : m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (model_ok) begin
      chk("o_valid", 64'(bus.o_valid), 64'(mq.size() != 0));
      chk("o_level", 64'(bus.o_level), 64'(mq.size()));
      chk("o_overflow", 64'(bus.o_overflow), 64'(m_ovf));
      if (mq.size() != 0) begin
        chk("o_data", 64'(bus.o_data), 64'(mq[0].data));
        chk("o_sop", 64'(bus.o_sop), 64'(mq[0].sop));
        chk("o_eop", 64'(bus.o_eop), 64'(mq[0].eop));
        chk("o_index", 64'(bus.o_index), 64'(mq[0].idx));
      end else begin
        chk("o_data_idle", 64'(bus.o_data), 64'd0);
        chk("o_sop_idle", 64'(bus.o_sop), 64'd0);
        chk("o_eop_idle", 64'(bus.o_eop), 64'd0);
        chk("o_index_idle", 64'(bus.o_index), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit bs, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.i_valid    = v;
    bus.i_bank_sel = bs;
    bus.i_rdata0   = d0;
    bus.i_rdata1   = d1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    int thresh;
    bus.i_point    = 11'd8;
    bus.i_valid    = 1'b0;
    bus.i_bank_sel = 1'b0;
    bus.i_rdata0   = '0;
    bus.i_rdata1   = '0;
    bus.i_ready    = 1'b1;
    do_reset();
    settle();
    chk("reset_level", 64'(bus.o_level), 64'd0);
    chk("reset_valid", 64'(bus.o_valid), 64'd0);

    // Eight-point frame, streaming straight through.
    bus.i_point = 11'd8;
    bus.i_ready = 1'b1;
    drive(1, 0, 32'd0, 32'hdead);
    settle();
    chk("first_data", 64'(bus.o_data), 64'd0);
    chk("first_sop", 64'(bus.o_sop), 64'd1);
    for (int i = 1; i < 8; i++) drive(1, 0, 32'(i), 32'hdead);
    settle();
    chk("last_data", 64'(bus.o_data), 64'd7);
    chk("last_eop", 64'(bus.o_eop), 64'd1);
    chk("last_index", 64'(bus.o_index), 64'd7);
    drive(0, 0, 0, 0);

    // Two four-point frames from alternate banks.
    bus.i_point = 11'd4;
    for (int i = 0; i < 8; i++) drive(1, (i >= 4), 32'(100 + i), 32'(200 + i));
    settle();
    chk("bank1_data", 64'(bus.o_data), 64'd207);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Backpressure: ten samples into an eight-deep FIFO.
    do_reset();
    bus.i_point = 11'd8;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive(1, 0, 32'(i + 50), 0);
    settle();
    chk("full_level", 64'(bus.o_level), 64'd8);
    chk("full_ovf", 64'(bus.o_overflow), 64'd1);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);
    settle();
    chk("drained_level", 64'(bus.o_level), 64'd0);
    chk("drained_ovf", 64'(bus.o_overflow), 64'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1, 0, 32'(i), 0);
    bus.i_ready = 1'b1;
    drive(1, 0, 32'h77, 0);
    settle();
    chk("pushpop_level", 64'(bus.o_level), 64'd8);
    chk("pushpop_ovf", 64'(bus.o_overflow), 64'd0);
    chk("pushpop_head", 64'(bus.o_index), 64'd1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);

    // Frame size change mid-frame.
    do_reset();
    bus.i_point = 11'd16;
    for (int i = 0; i < 5; i++) drive(1, 0, 32'(i), 0);
    bus.i_point = 11'd4;
    for (int i = 5; i < 16; i++) drive(1, 0, 32'(i), 0);
    settle();
    chk("resize_eop", 64'(bus.o_eop), 64'd1);
    chk("resize_idx", 64'(bus.o_index), 64'd15);
    for (int i = 0; i < 4; i++) drive(1, 0, 32'(i), 0);
    settle();
    chk("resize_next_idx", 64'(bus.o_index), 64'd3);
    chk("resize_next_eop", 64'(bus.o_eop), 64'd1);
    drive(0, 0, 0, 0);

    // Reset mid-frame with two entries queued.
    do_reset();
    bus.i_point = 11'd8;
    bus.i_ready = 1'b0;
    drive(1, 0, 32'h1, 0);
    drive(1, 0, 32'h2, 0);
    bus.i_ready = 1'b1;
    drive(1, 0, 32'h3, 0);
    settle();
    chk("pre_reset_level", 64'(bus.o_level), 64'd2);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    reset = 1'b0;
    settle();
    chk("post_reset_valid", 64'(bus.o_valid), 64'd0);
    chk("post_reset_level", 64'(bus.o_level), 64'd0);
    drive(1, 0, 32'h9, 0);
    settle();
    chk("post_reset_idx", 64'(bus.o_index), 64'd0);
    chk("post_reset_sop", 64'(bus.o_sop), 64'd1);

    // Randomized traffic with varying backpressure and frame sizes.
    thresh = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) thresh = $urandom_range(5, 100);
      case ($urandom % 5)
        0: bus.i_point = 11'($urandom_range(0, 1));
        1: bus.i_point = 11'($urandom_range(1025, 2047));
        2: bus.i_point = 11'($urandom_range(2, 6));
        default: bus.i_point = 11'($urandom_range(2, 20));
      endcase
      bus.i_ready = ($urandom_range(0, 99) < thresh);
      reset = ($urandom_range(0, 699) == 0);
      drive(($urandom % 4) != 0, $urandom % 2, DW'($urandom), DW'($urandom));
    end
    reset = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fft_out_stream.md
FFT_OUT_STREAM -- requirements
Module: fft_out_stream

Interface
REQ-001 Parameter DWIDTH, default 32, width of one complex sample in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, output FIFO entries; power of two, 4..64.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_point  input  11  FFT size, 2..1024.
REQ-006 i_valid  input  1  bank read data valid this cycle; one cycle after the bank read enable.
REQ-007 i_bank_sel  input  1  0 = bank 0 is the read bank, 1 = bank 1 is the read bank.
REQ-008 i_rdata0  input  DWIDTH  bank 0 read data.
REQ-009 i_rdata1  input  DWIDTH  bank 1 read data.
REQ-010 i_ready  input  1  downstream accepts the output beat.
REQ-011 o_data  output  DWIDTH  output sample, natural order.
REQ-012 o_valid  output  1  o_data, o_sop, o_eop and o_index are valid.
REQ-013 o_sop  output  1  beat is bin 0 of a frame.
REQ-014 o_eop  output  1  beat is the last bin of a frame.
REQ-015 o_index  output  10  bin index of the beat.
REQ-016 o_overflow  output  1  sticky flag: an input sample was dropped.
REQ-017 o_level  output  7  current FIFO occupancy.

Function
REQ-018 The captured sample SHALL be i_rdata1 when i_bank_sel=1, else i_rdata0, and SHALL be taken only in cycles with i_valid=1.
REQ-019 Bin counter r_idx (10 bits) SHALL advance by 1 on every i_valid cycle, including cycles whose sample is dropped, and SHALL wrap to 0 after reaching r_npt-1.
REQ-020 r_npt SHALL load from i_point when i_valid=1 and r_idx=0; a change of i_point mid-frame SHALL take effect only at the next frame.
REQ-021 An i_point value of 0, 1 or greater than 1024 SHALL be treated as 1024.
REQ-022 Each pushed entry SHALL hold {sample, sop = (r_idx==0), eop = (r_idx==npt-1), index = r_idx}; for a sample with r_idx=0, npt SHALL be the value loaded in that same cycle.
REQ-023 The FIFO SHALL be first-word fall-through: o_valid = (level != 0), and the outputs SHALL show the head entry.
REQ-024 A pop SHALL occur iff o_valid && i_ready; the outputs SHALL hold stable while o_valid && !i_ready.
REQ-025 A push SHALL occur iff i_valid && (level < FIFO_DEPTH || pop in the same cycle).
REQ-026 Latency: a sample pushed into an empty FIFO at edge N SHALL appear with o_valid=1 in the cycle after edge N.
REQ-027 Simultaneous push and pop SHALL leave level unchanged.
REQ-028 When full, a simultaneous push and pop SHALL accept the push.
REQ-029 When i_valid=1, the FIFO is full and there is no pop, the sample SHALL be dropped, o_overflow SHALL set and remain set until reset, and r_idx SHALL still advance.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH; o_level SHALL range 0..FIFO_DEPTH.
REQ-031 While o_valid=0, o_data, o_sop, o_eop and o_index SHALL be 0.

Reset
REQ-032 With reset=1 at a clock edge, after that edge: r_idx=0, r_npt=1024, FIFO empty, o_valid=0, o_level=0, o_overflow=0, o_data=0, o_sop=0, o_eop=0, o_index=0.
REQ-033 Reset asserted mid-frame SHALL discard FIFO contents; the first i_valid after reset is bin 0 with o_sop=1.

Verification
REQ-034 i_point=8, i_ready=1, 8 consecutive i_valid with i_bank_sel=0 and i_rdata0=0..7 -> o_data=0..7 each one cycle later, o_sop on the first beat, o_eop on the eighth, o_index 0..7, o_overflow=0.
REQ-035 i_point=4, two back-to-back frames, i_bank_sel=0 for frame 1 and 1 for frame 2 -> frame 1 data from i_rdata0, frame 2 from i_rdata1, o_sop at indices 0 and 4 of the stream, o_eop at 3 and 7.
REQ-036 FIFO_DEPTH=8, i_ready=0, 10 i_valid samples -> o_level=8, samples 9 and 10 dropped, o_overflow=1; after i_ready=1, exactly 8 beats with o_index 0..7 and o_overflow still 1.
REQ-037 Full FIFO, i_ready=1 and i_valid=1 in the same cycle -> push accepted, o_level stays 8, o_overflow=0.
REQ-038 i_point changed from 16 to 4 at r_idx=5 -> current frame ends at o_index=15 with o_eop; next frame o_index 0..3.
REQ-039 reset pulsed at r_idx=3 with 2 entries queued -> o_valid=0 and o_level=0 next cycle; next i_valid yields o_index=0, o_sop=1.
